// File: rtl/acappella_pkg.sv
`default_nettype none
// =============================================================================
// acappella_pkg : shared types and constants for the SDRAM access path
// Rev 1.0
// =============================================================================
package acappella_pkg;

  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_DATA_W = 32;

  localparam int CLI_LOAD   = 0;
  localparam int CLI_MIX    = 1;
  localparam int CLI_PITCH  = 2;
  localparam int CLI_RECORD = 3;
  localparam int CLI_PLAY   = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_DONE    = 3'd3,
    ST_GAP     = 3'd4
  } sdram_bridge_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// =============================================================================
// rr_arbiter : combinational round-robin search starting after last_grant
// Rev 1.0
// =============================================================================
module rr_arbiter
  import acappella_pkg::*;
#(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             valid_o
);

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % N);
  endfunction

  // Walk from the farthest candidate back to the nearest so the nearest requester wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req_i[wrap_idx(int'(last_grant_i) + k)]) begin
        grant_o = wrap_idx(int'(last_grant_i) + k);
        valid_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_access_bridge.sv
`default_nettype none
// =============================================================================
// sdram_access_bridge : round-robin multi-client bridge onto the SDRAM Avalon-MM slave
// Rev 1.0
// =============================================================================
module sdram_access_bridge
  import acappella_pkg::*;
#(
  parameter int N_CLIENTS = 5,
  parameter int ADDR_W    = SDRAM_ADDR_W,
  parameter int DATA_W    = SDRAM_DATA_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_CLIENTS-1:0] cli_read,
  input  logic [N_CLIENTS-1:0] cli_write,
  input  logic [ADDR_W-1:0]    cli_addr      [N_CLIENTS],
  input  logic [DATA_W-1:0]    cli_writedata [N_CLIENTS],
  output logic [DATA_W-1:0]    cli_readdata,
  output logic [N_CLIENTS-1:0] cli_finished,
  output logic [ADDR_W-1:0]    new_sdram_controller_0_s1_address,
  output logic [3:0]           new_sdram_controller_0_s1_byteenable_n,
  output logic                 new_sdram_controller_0_s1_chipselect,
  output logic [DATA_W-1:0]    new_sdram_controller_0_s1_writedata,
  output logic                 new_sdram_controller_0_s1_read_n,
  output logic                 new_sdram_controller_0_s1_write_n,
  input  logic [DATA_W-1:0]    new_sdram_controller_0_s1_readdata,
  input  logic                 new_sdram_controller_0_s1_readdatavalid,
  input  logic                 new_sdram_controller_0_s1_waitrequest
);

  localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  sdram_bridge_state_t   state_q, state_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic                  is_wr_q, is_wr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  cs_q, cs_d;
  logic                  rd_n_q, rd_n_d;
  logic                  wr_n_q, wr_n_d;
  logic [3:0]            be_n_q, be_n_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [N_CLIENTS-1:0]  fin_q, fin_d;

  logic [N_CLIENTS-1:0]  req;
  logic [IDX_W-1:0]      arb_grant;
  logic                  arb_valid;

  assign req = cli_read | cli_write;

  rr_arbiter #(
    .N     (N_CLIENTS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .valid_o      (arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    is_wr_d      = is_wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cs_d         = cs_q;
    rd_n_d       = rd_n_q;
    wr_n_d       = wr_n_q;
    be_n_d       = be_n_q;
    rdata_d      = rdata_q;
    fin_d        = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          // Write takes priority when a client raises both strobes.
          grant_d      = arb_grant;
          last_grant_d = arb_grant;
          is_wr_d      = cli_write[arb_grant];
          addr_d       = cli_addr[arb_grant];
          wdata_d      = cli_writedata[arb_grant];
          cs_d         = 1'b1;
          be_n_d       = 4'b0000;
          rd_n_d       = cli_write[arb_grant];
          wr_n_d       = ~cli_write[arb_grant];
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!new_sdram_controller_0_s1_waitrequest) begin
          cs_d   = 1'b0;
          be_n_d = 4'b1111;
          rd_n_d = 1'b1;
          wr_n_d = 1'b1;
          if (is_wr_q) begin
            fin_d[grant_q] = 1'b1;
            state_d        = ST_DONE;
          end else begin
            state_d = ST_WAIT_RD;
          end
        end
      end
      ST_WAIT_RD: begin
        if (new_sdram_controller_0_s1_readdatavalid) begin
          rdata_d        = new_sdram_controller_0_s1_readdata;
          fin_d[grant_q] = 1'b1;
          state_d        = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(N_CLIENTS - 1);
      grant_q      <= '0;
      is_wr_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cs_q         <= 1'b0;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      be_n_q       <= 4'b1111;
      rdata_q      <= '0;
      fin_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      is_wr_q      <= is_wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cs_q         <= cs_d;
      rd_n_q       <= rd_n_d;
      wr_n_q       <= wr_n_d;
      be_n_q       <= be_n_d;
      rdata_q      <= rdata_d;
      fin_q        <= fin_d;
    end
  end

  assign cli_readdata                           = rdata_q;
  assign cli_finished                           = fin_q;
  assign new_sdram_controller_0_s1_address      = addr_q;
  assign new_sdram_controller_0_s1_byteenable_n = be_n_q;
  assign new_sdram_controller_0_s1_chipselect   = cs_q;
  assign new_sdram_controller_0_s1_writedata    = wdata_q;
  assign new_sdram_controller_0_s1_read_n       = rd_n_q;
  assign new_sdram_controller_0_s1_write_n      = wr_n_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_access_bridge.sv
`default_nettype none
// tb_sdram_access_bridge : directed scenarios, scripted Avalon slave and a
// transaction-level reference model compared against the bridge every cycle.
module tb_sdram_access_bridge;

  localparam int N = 5;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]  rd = '0;
  logic [N-1:0]  wr = '0;
  logic [22:0]   addr [N];
  logic [31:0]   wdat [N];

  logic [31:0]   cli_rdata;
  logic [N-1:0]  fin;
  logic [22:0]   av_addr;
  logic [3:0]    av_be_n;
  logic          av_cs;
  logic [31:0]   av_wd;
  logic          av_rd_n;
  logic          av_wr_n;

  logic          s_wait  = 1'b0;
  logic          s_rdv   = 1'b0;
  logic [31:0]   s_rdata = '0;
  logic          x_rdv   = 1'b0;
  logic [31:0]   x_rdata = '0;
  logic          rdv_in;
  logic [31:0]   rdata_in;
  assign rdv_in   = s_rdv | x_rdv;
  assign rdata_in = x_rdv ? x_rdata : s_rdata;

  sdram_access_bridge dut (
    .i_clk                                   (clk),
    .i_rst                                   (rst_n),
    .cli_read                                (rd),
    .cli_write                               (wr),
    .cli_addr                                (addr),
    .cli_writedata                           (wdat),
    .cli_readdata                            (cli_rdata),
    .cli_finished                            (fin),
    .new_sdram_controller_0_s1_address       (av_addr),
    .new_sdram_controller_0_s1_byteenable_n  (av_be_n),
    .new_sdram_controller_0_s1_chipselect    (av_cs),
    .new_sdram_controller_0_s1_writedata     (av_wd),
    .new_sdram_controller_0_s1_read_n        (av_rd_n),
    .new_sdram_controller_0_s1_write_n       (av_wr_n),
    .new_sdram_controller_0_s1_readdata      (rdata_in),
    .new_sdram_controller_0_s1_readdatavalid (rdv_in),
    .new_sdram_controller_0_s1_waitrequest   (s_wait)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  always @(posedge clk) cyc++;

  // Scripted slave: stall each access slv_wait cycles, answer reads slv_lat cycles after acceptance.
  int          slv_wait = 0;
  int          slv_lat  = 1;
  logic [31:0] slv_data = '0;
  int          wcnt     = 0;
  int          lcnt     = 0;
  always @(posedge clk) begin
    #2;
    s_rdv = 1'b0;
    if (lcnt > 0) begin
      lcnt--;
      if (lcnt == 0) begin
        s_rdv   = 1'b1;
        s_rdata = slv_data;
      end
    end
    if (av_cs) begin
      if (wcnt < slv_wait) begin
        s_wait = 1'b1;
        wcnt++;
      end else begin
        s_wait = 1'b0;
        wcnt   = 0;
        if (!av_rd_n) lcnt = slv_lat;
      end
    end else begin
      s_wait = 1'b0;
      wcnt   = 0;
    end
  end

  // Reference model: one transaction at a time, described as its lifecycle
  // (on the bus -> awaiting data -> completion pulse -> dead cycle -> free).
  int          m_last  = N - 1;
  int          m_who   = 0;
  int          m_c     = 0;
  bit          m_write = 1'b0;
  bit          m_onbus = 1'b0;
  bit          m_await = 1'b0;
  bit          m_fin   = 1'b0;
  bit          m_gap   = 1'b0;
  bit          m_found = 1'b0;
  logic [22:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last = N - 1; m_who = 0; m_write = 1'b0;
      m_onbus = 1'b0; m_await = 1'b0; m_fin = 1'b0; m_gap = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (m_fin) begin
      m_fin = 1'b0;
      m_gap = 1'b1;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_onbus) begin
      if (!s_wait) begin
        m_onbus = 1'b0;
        if (m_write) m_fin = 1'b1;
        else         m_await = 1'b1;
      end
    end else if (m_await) begin
      if (rdv_in) begin
        m_rdata = rdata_in;
        m_await = 1'b0;
        m_fin   = 1'b1;
      end
    end else begin
      m_found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        m_c = (m_last + k) % N;
        if (!m_found && (rd[3'(m_c)] || wr[3'(m_c)])) begin
          m_found = 1'b1;
          m_who   = m_c;
          m_write = wr[3'(m_c)];
          m_addr  = addr[3'(m_c)];
          m_wdata = wdat[3'(m_c)];
        end
      end
      if (m_found) begin
        m_last  = m_who;
        m_onbus = 1'b1;
      end
    end
  end

  int fin_who [$];
  int fin_cyc [$];

  always @(negedge clk) begin
    chk("model_cs",    64'(av_cs),     64'(m_onbus));
    chk("model_rd_n",  64'(av_rd_n),   64'(!(m_onbus && !m_write)));
    chk("model_wr_n",  64'(av_wr_n),   64'(!(m_onbus && m_write)));
    chk("model_be_n",  64'(av_be_n),   m_onbus ? 64'h0 : 64'hF);
    chk("model_addr",  64'(av_addr),   64'(m_addr));
    chk("model_wdata", 64'(av_wd),     64'(m_wdata));
    chk("model_rdata", 64'(cli_rdata), 64'(m_rdata));
    chk("model_fin",   64'(fin),       m_fin ? (64'h1 << m_who) : 64'h0);
    for (int i = 0; i < N; i++) begin
      if (fin[i]) begin
        fin_who.push_back(i);
        fin_cyc.push_back(cyc);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cs"},    64'(av_cs),     64'h0);
    chk({tag, "_rd_n"},  64'(av_rd_n),   64'h1);
    chk({tag, "_wr_n"},  64'(av_wr_n),   64'h1);
    chk({tag, "_be_n"},  64'(av_be_n),   64'hF);
    chk({tag, "_addr"},  64'(av_addr),   64'h0);
    chk({tag, "_wdata"}, 64'(av_wd),     64'h0);
    chk({tag, "_rdata"}, 64'(cli_rdata), 64'h0);
    chk({tag, "_fin"},   64'(fin),       64'h0);
  endtask

  // Runs until any finished pulse is seen; returns 1 on success.
  task automatic wait_fin(input string name, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (fin != '0) got = 1'b1;
    end
    if (!got) timeout(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int n_rd_low;
    int n_wr_low;
    for (int i = 0; i < N; i++) begin
      addr[i] = '0;
      wdat[i] = '0;
    end
    step(2);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step(2);

    // Single write from client 3.
    addr[3] = 23'h000010;
    wdat[3] = 32'hDEADBEEF;
    wr[3]   = 1'b1;
    step();
    chk("wr1_write_n", 64'(av_wr_n), 64'h0);
    chk("wr1_cs",      64'(av_cs),   64'h1);
    chk("wr1_addr",    64'(av_addr), 64'h10);
    chk("wr1_wdata",   64'(av_wd),   64'hDEADBEEF);
    step();
    chk("wr1_write_n_released", 64'(av_wr_n), 64'h1);
    chk("wr1_fin",              64'(fin),     64'b01000);
    wr[3] = 1'b0;
    step();
    chk("wr1_fin_one_cycle", 64'(fin), 64'h0);
    step(2);

    // Read from client 4 with three stall cycles and two-cycle latency.
    slv_wait = 3;
    slv_lat  = 2;
    slv_data = 32'h12345678;
    addr[4]  = 23'h000020;
    rd[4]    = 1'b1;
    n_rd_low = 0;
    got      = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (!av_rd_n) begin
        n_rd_low++;
        chk("rd_addr_stable", 64'(av_addr), 64'h20);
      end
      if (fin != '0) got = 1'b1;
    end
    if (!got) timeout("rd_fin");
    chk("rd_read_n_cycles", 64'(n_rd_low),  64'd4);
    chk("rd_fin",           64'(fin),       64'b10000);
    chk("rd_data",          64'(cli_rdata), 64'h12345678);
    rd[4] = 1'b0;
    step(3);

    // Fairness: clients 0, 2, 4 hold write requests continuously.
    slv_wait = 0;
    addr[0] = 23'h100; addr[2] = 23'h200; addr[4] = 23'h400;
    wdat[0] = 32'hA0;  wdat[2] = 32'hA2;  wdat[4] = 32'hA4;
    fin_who.delete();
    fin_cyc.delete();
    wr[0] = 1'b1; wr[2] = 1'b1; wr[4] = 1'b1;
    for (int i = 0; i < 40 && fin_who.size() < 5; i++) step();
    wr = '0;
    if (fin_who.size() < 5) timeout("fair_count");
    else begin
      chk("fair_0", 64'(fin_who[0]), 64'd0);
      chk("fair_1", 64'(fin_who[1]), 64'd2);
      chk("fair_2", 64'(fin_who[2]), 64'd4);
      chk("fair_3", 64'(fin_who[3]), 64'd0);
      chk("fair_4", 64'(fin_who[4]), 64'd2);
      for (int i = 1; i < 5; i++)
        chk("fair_spacing", 64'(fin_cyc[i] - fin_cyc[i-1]), 64'd4);
    end
    step(3);

    // Client 1 raises read and write together: write wins.
    addr[1] = 23'h33;
    wdat[1] = 32'hA5A5A5A5;
    rd[1] = 1'b1;
    wr[1] = 1'b1;
    n_rd_low = 0;
    n_wr_low = 0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (!av_rd_n) n_rd_low++;
      if (!av_wr_n) n_wr_low++;
      if (fin != '0) got = 1'b1;
    end
    if (!got) timeout("both_fin");
    chk("both_read_n_low",  64'(n_rd_low), 64'd0);
    chk("both_write_n_low", 64'(n_wr_low), 64'd1);
    chk("both_fin",         64'(fin),      64'b00010);
    rd[1] = 1'b0;
    wr[1] = 1'b0;
    step(3);

    // Stale request: client 0 keeps its write high past finished.
    addr[0] = 23'h40;
    wr[0]   = 1'b1;
    wait_fin("stale_fin", 10, got);
    step();
    chk("stale_gap_cs",   64'(av_cs),   64'h0);
    chk("stale_gap_wr_n", 64'(av_wr_n), 64'h1);
    step();
    chk("stale_idle_cs",  64'(av_cs),   64'h0);
    step();
    chk("stale_regrant_cs",   64'(av_cs),   64'h1);
    chk("stale_regrant_wr_n", 64'(av_wr_n), 64'h0);
    wr[0] = 1'b0;
    step(4);

    // Stray readdatavalid while idle.
    x_rdata = 32'hCAFEF00D;
    x_rdv   = 1'b1;
    step();
    x_rdv   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stray_rdata", 64'(cli_rdata), 64'h12345678);
      chk("stray_fin",   64'(fin),       64'h0);
      chk("stray_cs",    64'(av_cs),     64'h0);
    end

    // Reset while waiting for read data.
    slv_wait = 0;
    slv_lat  = 5;
    slv_data = 32'h0BADF00D;
    addr[2]  = 23'h55AA;
    rd[2]    = 1'b1;
    step();
    chk("rst_issue_rd_n", 64'(av_rd_n), 64'h0);
    step();
    chk("rst_waitrd_cs",  64'(av_cs),   64'h0);
    rst_n = 1'b0;
    rd[2] = 1'b0;
    #1;
    chk_reset_vals("midrst");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("midrst_no_fin", 64'(fin), 64'h0);
    end
    chk("midrst_rdata", 64'(cli_rdata), 64'h0);

    // After reset client 0 is served ahead of client 4.
    fin_who.delete();
    fin_cyc.delete();
    wr[0] = 1'b1;
    wr[4] = 1'b1;
    for (int i = 0; i < 30 && fin_who.size() < 2; i++) step();
    wr = '0;
    if (fin_who.size() < 2) timeout("post_reset_order");
    else begin
      chk("post_reset_first",  64'(fin_who[0]), 64'd0);
      chk("post_reset_second", 64'(fin_who[1]), 64'd4);
    end
    step(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_access_bridge.md
# sdram_access_bridge

- Responder for the simple request interface used by the load, mix, pitch, record and play cores.
- Arbitrates up to N client cores round-robin and runs one transaction at a time as an Avalon-MM master on `new_sdram_controller_0_s1`.
- Returns `finished` and `readdata` to the granted client.
- Sits between the cores and the SDRAM controller in place of the hard-wired single-client path.

## Interface
- `N_CLIENTS`, 5: number of requesting cores; index 0 = load, 1 = mix, 2 = pitch, 3 = record, 4 = play.
- `ADDR_W`, 23: SDRAM word address width.
- `DATA_W`, 32: SDRAM data width.

- `i_clk`  in  1  single clock for the whole block.
- `i_rst`  in  1  asynchronous, active-low reset.
- `cli_read`  in  [N_CLIENTS-1:0]  per-client read request, level, held until that client's `finished`.
- `cli_write`  in  [N_CLIENTS-1:0]  per-client write request, level, held until that client's `finished`.
- `cli_addr`  in  [ADDR_W-1:0] x N_CLIENTS (unpacked)  per-client word address.
- `cli_writedata`  in  [DATA_W-1:0] x N_CLIENTS  per-client write data.
- `cli_readdata`  out  [DATA_W-1:0]  registered read data, broadcast to all clients.
- `cli_finished`  out  [N_CLIENTS-1:0]  one-hot, one-cycle completion pulse.
- `new_sdram_controller_0_s1_address`  out  [ADDR_W-1:0]  Avalon address.
- `new_sdram_controller_0_s1_byteenable_n`  out  4  active-low byte enables.
- `new_sdram_controller_0_s1_chipselect`  out  1  Avalon chipselect.
- `new_sdram_controller_0_s1_writedata`  out  [DATA_W-1:0]  Avalon write data.
- `new_sdram_controller_0_s1_read_n`  out  1  active-low read strobe.
- `new_sdram_controller_0_s1_write_n`  out  1  active-low write strobe.
- `new_sdram_controller_0_s1_readdata`  in  [DATA_W-1:0]  Avalon read data.
- `new_sdram_controller_0_s1_readdatavalid`  in  1  Avalon read data valid.
- `new_sdram_controller_0_s1_waitrequest`  in  1  Avalon wait request.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, DONE, GAP.
- **IDLE:** a client is requesting when its `cli_read` or `cli_write` is high.
  - Round-robin search starts at `last_grant+1` and wraps at N_CLIENTS-1 → 0.
  - The winner's index, opcode, address and data are latched; `last_grant` updates; next state is ISSUE.
  - If a client asserts both read and write, write wins and read is ignored.
- **ISSUE:** drives chipselect=1, byteenable_n=4'b0000, and the latched address/writedata.
  - Strobe: read_n=0 for a read, write_n=0 for a write.
  - Outputs are held unchanged while waitrequest=1.
  - On a cycle with waitrequest=0: write → DONE, read → WAIT_RD.
- **WAIT_RD:** all Avalon strobes are idle.
  - On readdatavalid=1, readdata is captured into `cli_readdata`; next state is DONE.
- **DONE:** `cli_finished[grant]`=1 for exactly this cycle; next state is GAP.
- **GAP:** a one-cycle dead cycle in which requests are ignored, so the client can drop its level request; next state is IDLE.
- Idle Avalon values: chipselect=0, read_n=1, write_n=1, byteenable_n=4'b1111. Address and writedata hold their last values.
- readdatavalid outside WAIT_RD is ignored, including a stray response after reset.

## Timing
- Reset values:
  - all Avalon outputs take their idle values; address=0; writedata=0.
  - `cli_readdata`=0; `cli_finished`=0.
  - state=IDLE; `last_grant`=N_CLIENTS-1, so client 0 is served first.
- All outputs are registered.
- A request seen in IDLE at cycle 0 gives ISSUE at cycle 1.
- Write with waitrequest=0: `finished` at cycle 2.
- Read: `finished` one cycle after readdatavalid, with `cli_readdata` valid in the same cycle as `finished` and held until the next read completes.
- Minimum spacing between two grants is 4 cycles for writes.
- Deasserting a request while it is granted does not abort the transaction; it completes and `finished` still pulses.
- Reset asserted mid-transaction returns to IDLE immediately with idle Avalon values. No `finished` is produced for the aborted request.

## Structure
- Shared package `acappella_pkg` holds:
  - the state enum `sdram_bridge_state_t`;
  - `SDRAM_ADDR_W`=23 and `SDRAM_DATA_W`=32;
  - client index constants `CLI_LOAD`, `CLI_MIX`, `CLI_PITCH`, `CLI_RECORD`, `CLI_PLAY`.
- One sub-module, `rr_arbiter`, contains the combinational round-robin search: inputs are the request vector and `last_grant`; outputs are a grant index and a valid flag.

## Test plan
- **Single write.** Client 3 writes addr 23'h000010, data 32'hDEADBEEF, waitrequest=0.
  - Expect write_n=0 and chipselect=1 for one cycle at cycle 1.
  - Expect `cli_finished`=5'b01000 at cycle 2.
- **Read with latency.** Client 4 reads addr 23'h000020; waitrequest=1 for 3 cycles, then readdatavalid 2 cycles after acceptance with 32'h12345678.
  - Expect read_n=0 for 4 cycles and address stable throughout.
  - Expect `cli_readdata`=32'h12345678 together with `cli_finished`[4].
- **Fairness.** Clients 0, 2 and 4 hold requests continuously.
  - Expect grant order 0, 2, 4, 0, 2.
  - Expect no client granted twice before the others are served.
- **Both strobes.** Client 1 asserts read and write together.
  - Expect write_n=0 and read_n to stay 1 throughout.
- **Stale request and stray data.**
  - A client that keeps its request high in the cycle after `finished` is not re-granted in GAP.
  - A readdatavalid pulse in IDLE changes nothing.
- **Reset mid-read.** Pull `i_rst` low while in WAIT_RD.
  - Expect all outputs at reset values immediately.
  - A later readdatavalid produces no `finished`.
